// File: rtl/tlb_array_lru_if.sv
// Request/response bundle between the TLB controller (master) and the
// set-associative TLB array (slave).
interface tlb_array_lru_if #(
    parameter int unsigned VPN_W    = 20,
    parameter int unsigned PPN_W    = 20,
    parameter int unsigned PERM_W   = 2,
    parameter int unsigned WAY_BITS = 2
);
    logic                lookup_valid;
    logic                lookup_ready;
    logic [VPN_W-1:0]    lookup_vpn;
    logic                resp_valid;
    logic                resp_hit;
    logic [WAY_BITS-1:0] resp_way;
    logic [PPN_W-1:0]    resp_ppn;
    logic [PERM_W-1:0]   resp_perms;
    logic                fill_valid;
    logic                fill_ready;
    logic [VPN_W-1:0]    fill_vpn;
    logic [PPN_W-1:0]    fill_ppn;
    logic [PERM_W-1:0]   fill_perms;
    logic                inv_valid;
    logic                inv_ready;
    logic [VPN_W-1:0]    inv_vpn;
    logic                flush_req;
    logic                flush_busy;
    logic                flush_done;

    modport master (
        output lookup_valid, lookup_vpn,
        output fill_valid, fill_vpn, fill_ppn, fill_perms,
        output inv_valid, inv_vpn,
        output flush_req,
        input  lookup_ready, fill_ready, inv_ready,
        input  resp_valid, resp_hit, resp_way, resp_ppn, resp_perms,
        input  flush_busy, flush_done
    );

    modport slave (
        input  lookup_valid, lookup_vpn,
        input  fill_valid, fill_vpn, fill_ppn, fill_perms,
        input  inv_valid, inv_vpn,
        input  flush_req,
        output lookup_ready, fill_ready, inv_ready,
        output resp_valid, resp_hit, resp_way, resp_ppn, resp_perms,
        output flush_busy, flush_done
    );
endinterface

// File: rtl/tlb_array_lru.sv
// Set-associative TLB array with registered lookup, true-LRU ages per set,
// victim selection on fill, single-entry invalidate and a set-by-set flush.
module tlb_array_lru #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned VPN_W    = 20,
    parameter int unsigned PPN_W    = 20,
    parameter int unsigned PERM_W   = 2,
    parameter int unsigned SET_BITS = $clog2(NUM_SETS),
    parameter int unsigned WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic           clk,
    input  logic           rst,
    tlb_array_lru_if.slave bus
);

    localparam logic [WAY_BITS-1:0] AGE_MAX  = WAY_BITS'(NUM_WAYS - 1);
    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(NUM_SETS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DONE
    } state_t;

    // Entry storage
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_BITS-1:0] age_q   [NUM_SETS][NUM_WAYS];
    logic [VPN_W-1:0]    vpn_q   [NUM_SETS][NUM_WAYS];
    logic [PPN_W-1:0]    ppn_q   [NUM_SETS][NUM_WAYS];
    logic [PERM_W-1:0]   perms_q [NUM_SETS][NUM_WAYS];

    // Flush FSM
    state_t              state_q;
    logic [SET_BITS-1:0] cnt_q;
    logic                flush_busy_q;
    logic                flush_done_q;

    // Registered response
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [WAY_BITS-1:0] resp_way_q;
    logic [PPN_W-1:0]    resp_ppn_q;
    logic [PERM_W-1:0]   resp_perms_q;

    // Command arbitration and shared tag compare
    logic                inv_ready;
    logic                fill_ready;
    logic                lookup_ready;
    logic                do_inv;
    logic                do_fill;
    logic                do_lookup;
    logic [VPN_W-1:0]    cmd_vpn;
    logic [SET_BITS-1:0] cmd_set;
    logic                cmd_hit;
    logic [WAY_BITS-1:0] cmd_way;
    logic                free_found;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] old_way;
    logic [WAY_BITS-1:0] fill_way;
    logic                touch_en;
    logic [WAY_BITS-1:0] touch_way;
    logic [WAY_BITS-1:0] touch_age;
    logic [WAY_BITS-1:0] age_touch [NUM_WAYS];

    assign inv_ready    = !flush_busy_q;
    assign fill_ready   = !flush_busy_q && !bus.inv_valid;
    assign lookup_ready = !flush_busy_q && !bus.inv_valid && !bus.fill_valid;

    assign do_inv    = bus.inv_valid    && inv_ready;
    assign do_fill   = bus.fill_valid   && fill_ready;
    assign do_lookup = bus.lookup_valid && lookup_ready;

    // Only the highest-priority pending command can be accepted, so a single
    // tag compare on its VPN serves inv, fill and lookup alike.
    always_comb begin
        cmd_vpn    = bus.inv_valid  ? bus.inv_vpn  :
                     bus.fill_valid ? bus.fill_vpn : bus.lookup_vpn;
        cmd_set    = cmd_vpn[SET_BITS-1:0];
        cmd_hit    = 1'b0;
        cmd_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        old_way    = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!cmd_hit && valid_q[cmd_set][w] && (vpn_q[cmd_set][w] == cmd_vpn)) begin
                cmd_hit = 1'b1;
                cmd_way = WAY_BITS'(w);
            end
            if (!free_found && !valid_q[cmd_set][w]) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(w);
            end
            if (age_q[cmd_set][w] == AGE_MAX) begin
                old_way = WAY_BITS'(w);
            end
        end
        fill_way = cmd_hit ? cmd_way : (free_found ? free_way : old_way);
    end

    // LRU touch: ways younger than the touched way age by one, touched way becomes 0.
    always_comb begin
        touch_en  = do_fill || (do_lookup && cmd_hit);
        touch_way = do_fill ? fill_way : cmd_way;
        touch_age = age_q[cmd_set][touch_way];
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (WAY_BITS'(w) == touch_way) begin
                age_touch[w] = '0;
            end else if (age_q[cmd_set][w] < touch_age) begin
                age_touch[w] = age_q[cmd_set][w] + 1'b1;
            end else begin
                age_touch[w] = age_q[cmd_set][w];
            end
        end
    end

    // Flush sequencer: walk every set once, then a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    flush_done_q <= 1'b0;
                    if (bus.flush_req) begin
                        state_q      <= S_FLUSH;
                        cnt_q        <= '0;
                        flush_busy_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SET_LAST) begin
                        state_q      <= S_DONE;
                        flush_busy_q <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    flush_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    flush_busy_q <= 1'b0;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits and ages: reset/flush restore, invalidate, fill install, LRU touch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_BITS'(w);
                end
            end
        end else if (state_q == S_FLUSH) begin
            valid_q[cnt_q] <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                age_q[cnt_q][w] <= WAY_BITS'(w);
            end
        end else begin
            if (do_inv && cmd_hit) begin
                valid_q[cmd_set][cmd_way] <= 1'b0;
            end
            if (do_fill) begin
                valid_q[cmd_set][fill_way] <= 1'b1;
            end
            if (touch_en) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    age_q[cmd_set][w] <= age_touch[w];
                end
            end
        end
    end

    // Translation payload written on fill; content is only observed behind valid.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            vpn_q[cmd_set][fill_way]   <= bus.fill_vpn;
            ppn_q[cmd_set][fill_way]   <= bus.fill_ppn;
            perms_q[cmd_set][fill_way] <= bus.fill_perms;
        end
    end

    // Lookup response, valid for exactly the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_ppn_q   <= '0;
            resp_perms_q <= '0;
        end else begin
            resp_valid_q <= do_lookup;
            resp_hit_q   <= do_lookup && cmd_hit;
            if (do_lookup && cmd_hit) begin
                resp_way_q   <= cmd_way;
                resp_ppn_q   <= ppn_q[cmd_set][cmd_way];
                resp_perms_q <= perms_q[cmd_set][cmd_way];
            end else begin
                resp_way_q   <= '0;
                resp_ppn_q   <= '0;
                resp_perms_q <= '0;
            end
        end
    end

    assign bus.inv_ready    = inv_ready;
    assign bus.fill_ready   = fill_ready;
    assign bus.lookup_ready = lookup_ready;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;
    assign bus.resp_ppn     = resp_ppn_q;
    assign bus.resp_perms   = resp_perms_q;
    assign bus.flush_busy   = flush_busy_q;
    assign bus.flush_done   = flush_done_q;

endmodule

// File: tb/tb_tlb_array_lru.sv
// Bench for tlb_array_lru: table of lookup/fill/invalidate operations with
// hand-derived expected responses, a response scoreboard, and hand-written
// sequences for command priority, flush timing and reset during flush.
module tb_tlb_array_lru;

    localparam int unsigned NUM_SETS = 16;
    localparam int unsigned NUM_WAYS = 4;
    localparam int unsigned VPN_W    = 20;
    localparam int unsigned PPN_W    = 20;
    localparam int unsigned PERM_W   = 2;
    localparam int unsigned WAY_BITS = 2;

    typedef enum logic [1:0] { OP_LOOKUP, OP_FILL, OP_INV } op_e;

    typedef struct {
        op_e         op;
        logic [19:0] vpn;
        logic [19:0] ppn;     // fill data, or expected ppn for lookups
        logic [1:0]  perms;   // fill data, or expected perms for lookups
        logic        hit;     // expected hit for lookups
        logic [1:0]  way;     // expected way for lookups
    } vec_t;

    typedef struct {
        string       name;
        logic        hit;
        logic [1:0]  way;
        logic [19:0] ppn;
        logic [1:0]  perms;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tlb_array_lru_if #(.VPN_W(VPN_W), .PPN_W(PPN_W), .PERM_W(PERM_W), .WAY_BITS(WAY_BITS)) bus ();

    tlb_array_lru #(
        .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS),
        .VPN_W(VPN_W),
        .PPN_W(PPN_W),
        .PERM_W(PERM_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t vecs[$];
    exp_t mon_e;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic void lu(input logic [19:0] vpn, input logic hit, input logic [1:0] way,
                               input logic [19:0] ppn, input logic [1:0] perms);
        vec_t v;
        v.op = OP_LOOKUP; v.vpn = vpn; v.ppn = ppn; v.perms = perms; v.hit = hit; v.way = way;
        vecs.push_back(v);
    endfunction

    function automatic void fl(input logic [19:0] vpn, input logic [19:0] ppn, input logic [1:0] perms);
        vec_t v;
        v.op = OP_FILL; v.vpn = vpn; v.ppn = ppn; v.perms = perms; v.hit = 1'b0; v.way = 2'd0;
        vecs.push_back(v);
    endfunction

    function automatic void iv(input logic [19:0] vpn);
        vec_t v;
        v.op = OP_INV; v.vpn = vpn; v.ppn = '0; v.perms = '0; v.hit = 1'b0; v.way = 2'd0;
        vecs.push_back(v);
    endfunction

    function automatic void push_exp(input logic [19:0] vpn, input logic hit, input logic [1:0] way,
                                     input logic [19:0] ppn, input logic [1:0] perms);
        exp_t e;
        e.name = $sformatf("resp_%05h", vpn);
        e.hit = hit; e.way = way; e.ppn = ppn; e.perms = perms;
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got resp_valid=1 way=%0d ppn=%05h required no response",
                         bus.resp_way, bus.resp_ppn);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.resp_hit, bus.resp_way, bus.resp_ppn, bus.resp_perms} !==
                    {mon_e.hit, mon_e.way, mon_e.ppn, mon_e.perms}) begin
                    failures++;
                    $display("FAIL %s: got hit=%0d way=%0d ppn=%05h perms=%0d required hit=%0d way=%0d ppn=%05h perms=%0d",
                             mon_e.name, bus.resp_hit, bus.resp_way, bus.resp_ppn, bus.resp_perms,
                             mon_e.hit, mon_e.way, mon_e.ppn, mon_e.perms);
                end
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic apply(input vec_t v);
        case (v.op)
            OP_LOOKUP: begin bus.lookup_valid = 1'b1; bus.lookup_vpn = v.vpn; end
            OP_FILL:   begin bus.fill_valid = 1'b1; bus.fill_vpn = v.vpn;
                             bus.fill_ppn = v.ppn; bus.fill_perms = v.perms; end
            default:   begin bus.inv_valid = 1'b1; bus.inv_vpn = v.vpn; end
        endcase
        #1;
        case (v.op)
            OP_LOOKUP: begin
                check1($sformatf("lookup_ready_%05h", v.vpn), bus.lookup_ready, 1);
                push_exp(v.vpn, v.hit, v.way, v.hit ? v.ppn : 20'h0, v.hit ? v.perms : 2'd0);
            end
            OP_FILL: check1($sformatf("fill_ready_%05h", v.vpn), bus.fill_ready, 1);
            default: check1($sformatf("inv_ready_%05h", v.vpn), bus.inv_ready, 1);
        endcase
        @(posedge clk); #1;
        bus.lookup_valid = 1'b0;
        bus.fill_valid   = 1'b0;
        bus.inv_valid    = 1'b0;
    endtask

    task automatic lookup1(input logic [19:0] vpn, input logic hit, input logic [1:0] way,
                           input logic [19:0] ppn, input logic [1:0] perms);
        vec_t v;
        v.op = OP_LOOKUP; v.vpn = vpn; v.ppn = ppn; v.perms = perms; v.hit = hit; v.way = way;
        apply(v);
    endtask

    initial begin
        int busy_cycles;
        int ready_err;
        logic done_seen;
        logic busy_in_done;

        bus.lookup_valid = 1'b0; bus.lookup_vpn = '0;
        bus.fill_valid   = 1'b0; bus.fill_vpn   = '0; bus.fill_ppn = '0; bus.fill_perms = '0;
        bus.inv_valid    = 1'b0; bus.inv_vpn    = '0;
        bus.flush_req    = 1'b0;

        // Set 3 = vpn[3:0]==3. Ages shown as [w0,w1,w2,w3] after each touch.
        lu(20'h00013, 0, 0, 20'h0, 0);
        fl(20'h00013, 20'hABCDE, 3);              // way0, ages [0,1,2,3]
        lu(20'h00013, 1, 0, 20'hABCDE, 3);
        fl(20'h00023, 20'h11111, 1);              // way1 [1,0,2,3]
        fl(20'h00033, 20'h22222, 2);              // way2 [2,1,0,3]
        fl(20'h00043, 20'h33333, 0);              // way3 [3,2,1,0]
        lu(20'h00023, 1, 1, 20'h11111, 1);        // [3,0,2,1]
        fl(20'h00053, 20'h44444, 3);              // evicts way0 [0,1,3,2]
        lu(20'h00013, 0, 0, 20'h0, 0);
        lu(20'h00053, 1, 0, 20'h44444, 3);
        fl(20'h00033, 20'h55555, 1);              // overwrite way2 [1,2,0,3]
        lu(20'h00033, 1, 2, 20'h55555, 1);
        lu(20'h00023, 1, 1, 20'h11111, 1);        // [2,0,1,3]
        lu(20'h00043, 1, 3, 20'h33333, 0);        // [3,1,2,0]
        fl(20'h00063, 20'h66666, 2);              // evicts way0 [0,2,3,1]
        lu(20'h00053, 0, 0, 20'h0, 0);
        lu(20'h00063, 1, 0, 20'h66666, 2);
        iv(20'h00023);                            // way1 invalid
        lu(20'h00023, 0, 0, 20'h0, 0);
        fl(20'h00073, 20'h77777, 3);              // lowest invalid way1, not oldest way2 [1,0,3,2]
        lu(20'h00073, 1, 1, 20'h77777, 3);
        iv(20'h00083);                            // miss: no-op
        lu(20'h00043, 1, 3, 20'h33333, 0);        // [2,1,3,0]
        fl(20'h00093, 20'h99999, 1);              // evicts way2 [3,2,0,1]
        lu(20'h00033, 0, 0, 20'h0, 0);
        lu(20'h00093, 1, 2, 20'h99999, 1);
        lu(20'h00063, 1, 0, 20'h66666, 2);
        lu(20'h10013, 0, 0, 20'h0, 0);            // same set, upper VPN bits differ
        lu(20'h00014, 0, 0, 20'h0, 0);
        fl(20'h00014, 20'h14141, 1);
        lu(20'h00014, 1, 0, 20'h14141, 1);
        fl(20'hFFFFF, 20'hFEDCB, 2);
        lu(20'hFFFFF, 1, 0, 20'hFEDCB, 2);
        fl(20'h00000, 20'h00001, 3);
        lu(20'h00000, 1, 0, 20'h00001, 3);
        fl(20'h00026, 20'h26262, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check1("rst_resp_valid", bus.resp_valid, 0);
        check1("rst_resp_hit", bus.resp_hit, 0);
        check1("rst_resp_ppn", bus.resp_ppn, 0);
        check1("rst_flush_busy", bus.flush_busy, 0);
        check1("rst_flush_done", bus.flush_done, 0);
        check1("rst_lookup_ready", bus.lookup_ready, 1);
        check1("rst_fill_ready", bus.fill_ready, 1);
        check1("rst_inv_ready", bus.inv_ready, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Priority: inv beats fill beats lookup.
        bus.inv_valid = 1'b1;  bus.inv_vpn = 20'h00073;
        bus.fill_valid = 1'b1; bus.fill_vpn = 20'h000A5; bus.fill_ppn = 20'hA5A5A; bus.fill_perms = 2'd1;
        bus.lookup_valid = 1'b1; bus.lookup_vpn = 20'h00014;
        #1;
        check1("prio_inv_ready", bus.inv_ready, 1);
        check1("prio_fill_ready", bus.fill_ready, 0);
        check1("prio_lookup_ready_a", bus.lookup_ready, 0);
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        #1;
        check1("prio_fill_ready_next", bus.fill_ready, 1);
        check1("prio_lookup_ready_b", bus.lookup_ready, 0);
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        bus.lookup_valid = 1'b0;
        lookup1(20'h00073, 0, 0, 20'h0, 0);
        lookup1(20'h000A5, 1, 0, 20'hA5A5A, 1);

        // Flush with a lookup accepted in the request cycle; lookup held through the flush.
        bus.flush_req = 1'b1;
        bus.lookup_valid = 1'b1; bus.lookup_vpn = 20'h00014;
        #1;
        check1("flush_start_lookup_ready", bus.lookup_ready, 1);
        push_exp(20'h00014, 1, 0, 20'h14141, 1);
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        busy_cycles = 0; ready_err = 0; done_seen = 1'b0; busy_in_done = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (bus.flush_busy) begin
                busy_cycles++;
                if (bus.lookup_ready || bus.fill_ready || bus.inv_ready) ready_err++;
            end
            if (bus.flush_done) begin
                done_seen = 1'b1;
                busy_in_done = bus.flush_busy;
                push_exp(20'h00014, 0, 0, 20'h0, 0);   // accepted during DONE, set already cleared
            end else begin
                @(posedge clk); #1;
            end
        end
        check1("flush_busy_cycles", busy_cycles, 16);
        check1("flush_done_seen", done_seen, 1);
        check1("flush_busy_in_done", busy_in_done, 0);
        check1("flush_ready_low", ready_err, 0);
        @(posedge clk); #1;
        bus.lookup_valid = 1'b0;
        check1("flush_done_one_cycle", bus.flush_done, 0);
        check1("flush_busy_after", bus.flush_busy, 0);
        lookup1(20'hFFFFF, 0, 0, 20'h0, 0);
        lookup1(20'h00000, 0, 0, 20'h0, 0);
        lookup1(20'h00043, 0, 0, 20'h0, 0);
        lookup1(20'h000A5, 0, 0, 20'h0, 0);
        lookup1(20'h00026, 0, 0, 20'h0, 0);
        begin
            vec_t f;
            f.op = OP_FILL; f.vpn = 20'h00013; f.ppn = 20'h0BEEF; f.perms = 2'd2; f.hit = 1'b0; f.way = 2'd0;
            apply(f);
        end
        lookup1(20'h00013, 1, 0, 20'h0BEEF, 2);

        // Reset in the middle of a flush.
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        check1("mid_flush_busy", bus.flush_busy, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check1("rst_mid_flush_busy", bus.flush_busy, 0);
        check1("rst_mid_flush_done", bus.flush_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check1("after_rst_busy", bus.flush_busy, 0);
        check1("after_rst_lookup_ready", bus.lookup_ready, 1);
        lookup1(20'h00013, 0, 0, 20'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        check1("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_array_lru.md
Name: tlb_array_lru

Overview:
Parametrised set-associative TLB array: generation-two storage for the TLB datapath.
- Adds registered lookup with hit/way reporting and true-LRU age maintenance.
- Adds internal victim selection on fill, single-entry invalidate, and a multi-cycle flush-all state machine.
- Sits between the TLB controller (lookup/fill/invalidate/flush requests) and the page-walk return path.

Parameters:
NUM_SETS, 16, number of sets; power of two, >=2
NUM_WAYS, 4, associativity; power of two, >=2
VPN_W, 20, virtual page number width
PPN_W, 20, physical page number width
PERM_W, 2, permission field width
SET_BITS, $clog2(NUM_SETS), derived; set index = vpn[SET_BITS-1:0]
WAY_BITS, $clog2(NUM_WAYS), derived; also age counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
lookup_valid  in  1  lookup request
lookup_ready  out  1  lookup accepted when valid&&ready
lookup_vpn  in  VPN_W  VPN to translate
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  translation present
resp_way  out  WAY_BITS  hitting way (0 on miss)
resp_ppn  out  PPN_W  PPN on hit, 0 on miss
resp_perms  out  PERM_W  perms on hit, 0 on miss
fill_valid  in  1  install translation
fill_ready  out  1  fill accepted when valid&&ready
fill_vpn  in  VPN_W  VPN to install
fill_ppn  in  PPN_W  PPN to install
fill_perms  in  PERM_W  perms to install
inv_valid  in  1  invalidate entry matching inv_vpn
inv_ready  out  1  invalidate accepted when valid&&ready
inv_vpn  in  VPN_W  VPN to invalidate
flush_req  in  1  start flush-all (pulse or level)
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse at flush end

Behaviour:
- Entry fields: valid, vpn (full VPN stored and compared), ppn, perms, age[WAY_BITS].
- Reset:
  - All valid=0 and ages set to age[w]=w (ages in a set are always a permutation of 0..NUM_WAYS-1).
  - All outputs 0 except ready signals, which are 1 from the first cycle after reset.
  - FSM returns to IDLE, including when reset is asserted mid-flush.
- Command priority each cycle: flush FSM active > inv > fill > lookup.
  - inv_ready = !flush_busy.
  - fill_ready = !flush_busy && !inv_valid.
  - lookup_ready = !flush_busy && !inv_valid && !fill_valid.
- Lookup:
  - Accepted at edge T; tags compared combinationally against the pre-edge array state.
  - resp_* registered and valid during cycle T+1 only; resp_valid=0 otherwise.
  - Multiple matching ways cannot occur (fill de-duplicates); if forced, the lowest way wins.
- LRU touch of way h in a set (on lookup hit or fill), applied at the acceptance edge:
  - Every way with age < age[h] increments; age[h] becomes 0; others unchanged.
  - Lookup misses leave ages untouched.
- Fill, completes in one edge, no response:
  - If fill_vpn already matches a valid way, that way is overwritten.
  - Otherwise the lowest-index invalid way is used.
  - Otherwise the way with age == NUM_WAYS-1 is used.
  - The chosen way is written with valid=1 and touched.
- Invalidate, one edge:
  - The matching valid way is cleared to valid=0; ppn, perms and ages are unchanged.
  - A miss is a no-op.
- Flush FSM:
  - IDLE: flush_req=1 -> FLUSH, set counter=0, flush_busy=1 from the next cycle.
  - FLUSH: each cycle clears all valids of set[counter] and restores age[w]=w, then counter++.
    - After set NUM_SETS-1 -> DONE.
    - Takes exactly NUM_SETS cycles.
  - DONE: flush_done=1 for one cycle, flush_busy=0 -> IDLE.
  - flush_req while FLUSH/DONE is ignored; a level-held flush_req restarts from IDLE.
- A lookup accepted in the cycle flush_req rises completes normally; resp occurs during the first FLUSH cycle.
- The counter wraps naturally with no overflow state.

Test Plan:
- Reset, then lookup VPN 0x00013 -> next cycle resp_valid=1, resp_hit=0, resp_ppn=0; lookup_ready=1.
- Fill VPN 0x00013/PPN 0xABCDE/perms 2'b11, then lookup 0x00013 -> resp_hit=1, resp_way=0, ppn=0xABCDE, perms=3; way0 age=0.
- Fill 5 distinct VPNs into set 3 (NUM_WAYS=4), then re-hit way1 before the 5th fill -> 5th fill evicts way0 (oldest); lookup of the first VPN misses.
- Refill an existing VPN with a new PPN -> same way overwritten, no other way changes, subsequent lookup returns the new PPN.
- Same-cycle inv_valid, fill_valid and lookup_valid -> only inv accepted (fill_ready=0, lookup_ready=0); next cycle fill accepted.
- Fill 8 entries, pulse flush_req -> flush_busy high 16 cycles, flush_done pulse, all ready low meanwhile; all lookups then miss; assert rst mid-flush -> flush_busy=0 next cycle.
